// File: rtl/ddr_ring_buffer_pkg.sv
// Shared definitions for the ring-buffer datapath: burst-reader FSM state
// encoding and the burst-length clamp helper.
package ddr_ring_buffer_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
    localparam logic [ST_W-1:0] ST_DATA = 2'd2;

    // Operand width of the clamp helper; callers extend into it and truncate back.
    localparam int unsigned CALC_W = 32;

    function automatic logic [CALC_W-1:0] min_fill(
        input logic [CALC_W-1:0] fill,
        input logic [CALC_W-1:0] burst
    );
        return (fill < burst) ? fill : burst;
    endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO in bursts: announces each burst with a length
// descriptor, then streams exactly that many words through one output register.
module fifo_burst_reader
    import ddr_ring_buffer_pkg::*;
#(
    parameter int unsigned BW      = 8,
    parameter int unsigned LGFLEN  = 4,
    parameter int unsigned LGBURST = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,

    output logic               o_fifo_rd,
    input  logic [BW-1:0]      i_fifo_data,
    input  logic               i_fifo_empty,
    input  logic [LGFLEN:0]    i_fifo_fill,
    input  logic               i_flush,

    output logic               o_req_valid,
    input  logic               i_req_ready,
    output logic [LGBURST:0]   o_req_len,

    output logic               o_valid,
    input  logic               i_ready,
    output logic [BW-1:0]      o_data,
    output logic               o_last,

    output logic               o_busy
);

    localparam int unsigned FILL_W    = LGFLEN + 1;
    localparam int unsigned LEN_W     = LGBURST + 1;
    localparam int unsigned BURST_LEN = 1 << LGBURST;
    localparam int unsigned TMO_W     = $clog2(TIMEOUT);

    logic [ST_W-1:0]   state_q,     state_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic [LEN_W-1:0]  rem_q,       rem_d;
    logic [TMO_W-1:0]  tmo_q,       tmo_d;
    logic              req_valid_q, req_valid_d;
    logic              valid_q,     valid_d;
    logic [BW-1:0]     data_q,      data_d;
    logic              last_q,      last_d;
    logic              busy_q,      busy_d;

    logic              fill_nz_c;
    logic              fill_full_c;
    logic              tmo_hit_c;
    logic              trigger_c;
    logic [LEN_W-1:0]  fill_len_c;
    logic              pop_c;
    logic              beat_taken_c;

    // Burst trigger evaluation, only meaningful while idle.
    assign fill_nz_c   = (i_fifo_fill != '0);
    assign fill_full_c = (i_fifo_fill >= FILL_W'(BURST_LEN));
    assign tmo_hit_c   = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign trigger_c   = fill_full_c | (fill_nz_c & tmo_hit_c) | (fill_nz_c & i_flush);
    assign fill_len_c  = LEN_W'(min_fill(CALC_W'(i_fifo_fill), CALC_W'(BURST_LEN)));

    // Pop whenever words remain and the output register is free or draining.
    assign beat_taken_c = valid_q & i_ready;
    assign pop_c        = (state_q == ST_DATA) && (rem_q != '0) && !i_fifo_empty
                          && (!valid_q || i_ready);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rem_d       = rem_q;
        tmo_d       = '0;
        req_valid_d = req_valid_q;
        valid_d     = valid_q;
        data_d      = data_q;
        last_d      = last_q;

        case (state_q)
            ST_IDLE: begin
                if (trigger_c) begin
                    state_d     = ST_REQ;
                    len_d       = fill_len_c;
                    req_valid_d = 1'b1;
                end else if (fill_nz_c && !fill_full_c) begin
                    tmo_d = tmo_hit_c ? tmo_q : tmo_q + TMO_W'(1);
                end
            end

            ST_REQ: begin
                if (i_req_ready) begin
                    state_d     = ST_DATA;
                    req_valid_d = 1'b0;
                    rem_d       = len_q;
                end
            end

            ST_DATA: begin
                if (pop_c) begin
                    valid_d = 1'b1;
                    data_d  = i_fifo_data;
                    last_d  = (rem_q == LEN_W'(1));
                    rem_d   = rem_q - LEN_W'(1);
                end else if (beat_taken_c) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                if (beat_taken_c && last_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_valid_d = 1'b0;
                valid_d     = 1'b0;
                last_d      = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            rem_q       <= '0;
            tmo_q       <= '0;
            req_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            tmo_q       <= tmo_d;
            req_valid_q <= req_valid_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    // The pop strobe must be combinational for a show-ahead FIFO; reset masks it.
    assign o_fifo_rd   = pop_c & ~i_reset;
    assign o_req_valid = req_valid_q;
    assign o_req_len   = len_q;
    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_last      = last_q;
    assign o_busy      = busy_q;

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter BW, 8, data width in bits.
REQ-002 Parameter LGFLEN, 4, log2 of the upstream FIFO depth; the fill input is LGFLEN+1 bits.
REQ-003 Parameter LGBURST, 3, log2 of the maximum burst length; BURST_LEN = 2^LGBURST, SHALL be <= 2^LGFLEN.
REQ-004 Parameter TIMEOUT, 64, idle cycles with partial data before a short burst is forced; SHALL be >= 2.
REQ-005 i_clk  in  1  clock; reset i_reset, synchronous, active-high; clock i_clk.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 o_fifo_rd  out  1  pop strobe to the show-ahead FIFO.
REQ-008 i_fifo_data  in  BW  FIFO head word, valid combinationally while i_fifo_empty is low.
REQ-009 i_fifo_empty  in  1  FIFO empty flag.
REQ-010 i_fifo_fill  in  LGFLEN+1  FIFO occupancy.
REQ-011 i_flush  in  1  level request to drain any residual words immediately.
REQ-012 o_req_valid / i_req_ready / o_req_len[LGBURST:0]  out/in/out  burst descriptor handshake; length is in words, 1..BURST_LEN.
REQ-013 o_valid / i_ready / o_data[BW-1:0] / o_last  out/in/out/out  data beat stream.
REQ-014 o_busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ and DATA.
REQ-016 In IDLE, a trigger SHALL be any of: fill >= BURST_LEN; fill > 0 with the timeout counter == TIMEOUT-1; fill > 0 with i_flush high.
REQ-017 On a trigger, the block SHALL latch len = min(fill, BURST_LEN) and enter REQ on the next cycle; o_req_valid SHALL rise exactly 1 cycle after the trigger cycle.
REQ-018 The timeout counter SHALL increment each IDLE cycle while 0 < fill < BURST_LEN, SHALL clear otherwise and on leaving IDLE, and SHALL saturate at TIMEOUT-1.
REQ-019 In REQ, o_req_valid SHALL be high and o_req_len SHALL equal len, both held stable until i_req_ready; the handshake SHALL move the FSM to DATA.
REQ-020 In DATA, o_fifo_rd SHALL equal remaining>0 AND !i_fifo_empty AND (!o_valid OR i_ready); no pop SHALL occur outside DATA.
REQ-021 On a pop, o_data SHALL load i_fifo_data and o_valid SHALL be set on the following cycle; o_valid SHALL clear when a beat is accepted with no new pop.
REQ-022 With i_ready held high, the block SHALL sustain one beat per cycle; the first o_valid SHALL come 2 cycles after the REQ handshake cycle.
REQ-023 o_data and o_last SHALL be held stable while o_valid && !i_ready.
REQ-024 o_last SHALL be high only on beat number len of the burst.
REQ-025 Acceptance of the last beat SHALL return the FSM to IDLE; the next trigger SHALL be evaluated from the following cycle.
REQ-026 An empty FIFO in DATA (a protocol violation) SHALL stall without popping, and no beat SHALL be produced.
REQ-027 i_flush SHALL be ignored outside IDLE and with fill == 0.
REQ-028 Beat counters SHALL be LGBURST+1 bits wide; a burst of len == BURST_LEN SHALL not wrap.

Reset
REQ-029 i_reset SHALL force IDLE, clear the timeout and beat counters, and drive o_fifo_rd, o_req_valid, o_valid, o_last and o_busy to 0; o_req_len and o_data SHALL be 0.
REQ-030 A reset mid-burst SHALL abandon the burst without further pops; words already popped are lost, and the FIFO is reset separately.

Structure
REQ-031 The FSM state enumeration and the minimum-of-fill helper width constants SHALL reside in the shared ddr_ring_buffer_pkg package.
REQ-032 The block SHALL be a single module with one embedded output register stage; no sub-module is required.

Verification
REQ-033 Scenario: BURST_LEN=8, fill 8, ready always high -> o_req_len=8, 8 consecutive beats with in-order data, o_last on beat 8, FSM back to IDLE.
REQ-034 Scenario: fill 3 with no further writes -> o_req_valid asserted TIMEOUT cycles later, len 3, o_last on beat 3.
REQ-035 Scenario: fill 5 with i_flush pulsed -> o_req_valid next cycle, len 5.
REQ-036 Scenario: i_ready toggled 1/0 during the burst -> no data lost or duplicated, outputs stable while stalled, exactly len pops.
REQ-037 Scenario: i_req_ready held low for 10 cycles -> o_req_len stable, no pops until the handshake.
REQ-038 Scenario: i_reset asserted at beat 4 of 8 -> all outputs 0 the next cycle, the following burst starts cleanly from IDLE.
